// File: rtl/spart_bus_arbiter_if.sv
// Client-side request/response bundle of the SPART bus arbiter.
// Client i owns bit i of req/req_rd/done and byte i of req_wdata.
interface spart_bus_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ-1:0]   req_rd;
  logic [8*NUM_REQ-1:0] req_wdata;
  logic [NUM_REQ-1:0]   done;
  logic [7:0]           rdata;

  modport master (
    output req, req_rd, req_wdata,
    input  done, rdata
  );

  modport slave (
    input  req, req_rd, req_wdata,
    output done, rdata
  );
endinterface

// File: rtl/spart_bus_arbiter.sv
// Owns the SPART processor bus: programs the baud divisor after reset or cfg_load,
// then grants single-byte RX reads / TX writes round-robin, gated by rda/tbr.
module spart_bus_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          br_cfg,
  input  logic                cfg_load,
  spart_bus_arbiter_if.slave  cli,
  output logic                cfg_busy,
  output logic                iocs,
  output logic                iorw,
  output logic [1:0]          ioaddr,
  inout  wire  [7:0]          databus,
  input  logic                rda,
  input  logic                tbr
);

  typedef enum logic [2:0] {CFG_LO, CFG_HI, IDLE, XFER, GAP} state_t;
  typedef logic [1:0] idx_t;

  state_t      state;
  logic [15:0] div_reg;
  logic        cfg_pend;
  idx_t        rr_ptr;
  idx_t        sel;
  logic        xfer_rd;
  logic [7:0]  xfer_wdata;

  logic [NUM_REQ-1:0] elig;
  logic               pick_found;
  idx_t               pick;
  logic               pick_rd;
  logic [7:0]         pick_wdata;

  logic               drv_en;
  logic [7:0]         drv_data;

  function automatic logic [15:0] div_lookup(input logic [1:0] cfg);
    case (cfg)
      2'b00:   div_lookup = 16'd10416;
      2'b01:   div_lookup = 16'd5208;
      2'b10:   div_lookup = 16'd2604;
      default: div_lookup = 16'd1302;
    endcase
  endfunction

  // NOTE: every always_comb output gets a default before any branch, so no path leaves it unassigned (no latch).
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++)
      elig[i] = cli.req[i] & (cli.req_rd[i] ? rda : tbr);
  end

  // Lowest eligible index wins overall, then the lowest one above rr_ptr overrides it:
  // together that is a scan of rr_ptr+1, rr_ptr+2, ... with wrap-around.
  always_comb begin
    pick_found = 1'b0;
    pick       = '0;
    pick_rd    = 1'b1;
    pick_wdata = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (elig[i]) begin
        pick_found = 1'b1;
        pick       = idx_t'(i);
        pick_rd    = cli.req_rd[i];
        pick_wdata = cli.req_wdata[8*i +: 8];
      end
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (elig[i] && (i > int'(rr_ptr))) begin
        pick       = idx_t'(i);
        pick_rd    = cli.req_rd[i];
        pick_wdata = cli.req_wdata[8*i +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= CFG_LO;
      div_reg    <= '0;
      cfg_pend   <= 1'b0;
      rr_ptr     <= idx_t'(NUM_REQ - 1);
      sel        <= '0;
      xfer_rd    <= 1'b1;
      xfer_wdata <= '0;
      cli.done   <= '0;
      cli.rdata  <= '0;
    end else begin
      cli.done <= '0;
      if (cfg_load) cfg_pend <= 1'b1;
      case (state)
        CFG_LO: begin
          div_reg  <= div_lookup(br_cfg);
          cfg_pend <= 1'b0;
          state    <= CFG_HI;
        end
        CFG_HI: begin
          cfg_pend <= 1'b0;
          state    <= IDLE;
        end
        IDLE: begin
          if (cfg_pend) begin
            state <= CFG_LO;
          end else if (pick_found) begin
            sel        <= pick;
            xfer_rd    <= pick_rd;
            xfer_wdata <= pick_wdata;
            state      <= XFER;
          end
        end
        XFER: begin
          if (xfer_rd) cli.rdata <= databus;
          rr_ptr <= sel;
          for (int i = 0; i < NUM_REQ; i++)
            cli.done[i] <= (sel == idx_t'(i));
          state <= GAP;
        end
        GAP:     state <= IDLE;
        default: state <= CFG_LO;
      endcase
    end
  end

  // Bus controls are decoded from state so CFG_LO can present the live table value;
  // qualifying with rst releases the bus the instant reset asserts.
  always_comb begin
    iocs     = 1'b0;
    iorw     = 1'b1;
    ioaddr   = 2'b00;
    drv_en   = 1'b0;
    drv_data = 8'h00;
    if (rst) begin
      case (state)
        CFG_LO: begin
          iocs     = 1'b1;
          iorw     = 1'b0;
          ioaddr   = 2'b10;
          drv_en   = 1'b1;
          drv_data = div_lookup(br_cfg) & 16'h00FF;
        end
        CFG_HI: begin
          iocs     = 1'b1;
          iorw     = 1'b0;
          ioaddr   = 2'b11;
          drv_en   = 1'b1;
          drv_data = div_reg[15:8];
        end
        XFER: begin
          iocs     = 1'b1;
          iorw     = xfer_rd;
          drv_en   = ~xfer_rd;
          drv_data = xfer_wdata;
        end
        default: ;
      endcase
    end
  end

  assign databus  = drv_en ? drv_data : 8'hzz;
  assign cfg_busy = rst && ((state == CFG_LO) || (state == CFG_HI));

endmodule

// File: tb/tb_spart_bus_arbiter.sv
// Scoreboarded bench for spart_bus_arbiter: the driver predicts bus cycles and done pulses
// from round-robin rules into queues; a negedge monitor pops and compares.
module tb_spart_bus_arbiter;
  localparam int N = 3;

  typedef struct packed { logic rd; logic [1:0] addr; logic [7:0] data; } bus_ev_t;
  typedef struct packed { logic [N-1:0] oh; logic [7:0] rdata; } done_ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] br_cfg = 2'b10;
  logic       cfg_load = 1'b0;
  logic       rda = 1'b0;
  logic       tbr = 1'b0;
  logic       cfg_busy, iocs, iorw;
  logic [1:0] ioaddr;
  wire  [7:0] databus;

  spart_bus_arbiter_if #(.NUM_REQ(N)) cli_if ();

  spart_bus_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .rst(rst), .br_cfg(br_cfg), .cfg_load(cfg_load), .cli(cli_if),
    .cfg_busy(cfg_busy), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
    .databus(databus), .rda(rda), .tbr(tbr)
  );

  always #5 clk = ~clk;

  // SPART model: presents the next RX byte whenever the arbiter is not writing.
  logic [7:0] rx_bytes [256];
  logic [7:0] spart_rd = 8'd0;
  assign databus = (iocs && !iorw) ? 8'hzz : rx_bytes[spart_rd];
  always @(posedge clk) if (iocs && iorw) spart_rd <= spart_rd + 8'd1;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bus_ev_t  bus_q[$];
  done_ev_t done_q[$];
  int       checks = 0;
  int       failures = 0;
  bit       b2b_chk = 1'b0;

  int         last = N - 1;
  logic [7:0] model_rd = 8'd0;
  logic [7:0] last_rd = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin : monitor
    int prev_x;
    int last_x;
    bus_ev_t  be;
    done_ev_t de;
    prev_x = -1;
    last_x = -10;
    forever begin
      @(negedge clk);
      if (!b2b_chk) prev_x = -1;
      if (!rst) begin
        check("rst_iocs", 32'(iocs), 32'd0);
        check("rst_done", 32'(cli_if.done), 32'd0);
      end else begin
        if (iocs) begin
          check("bus_expected", 32'(bus_q.size() != 0), 32'd1);
          if (bus_q.size() != 0) begin
            be = bus_q.pop_front();
            check("bus_rw", 32'(iorw), 32'(be.rd));
            check("bus_addr", 32'(ioaddr), 32'(be.addr));
            check("bus_data", 32'(databus), 32'(be.data));
          end
          if (ioaddr == 2'b00) begin
            if (b2b_chk && prev_x >= 0) check("grant_spacing", 32'(cyc - prev_x), 32'd3);
            prev_x = cyc;
            last_x = cyc;
          end
        end
        if (cli_if.done != '0) begin
          check("done_expected", 32'(done_q.size() != 0), 32'd1);
          if (done_q.size() != 0) begin
            de = done_q.pop_front();
            check("done_onehot", 32'(cli_if.done), 32'(de.oh));
            check("rdata", 32'(cli_if.rdata), 32'(de.rdata));
            check("done_latency", 32'(cyc - last_x), 32'd1);
          end
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [15:0] div_of(input logic [1:0] cfg);
    case (cfg)
      2'b00:   return 16'd10416;
      2'b01:   return 16'd5208;
      2'b10:   return 16'd2604;
      default: return 16'd1302;
    endcase
  endfunction

  // First requester after the last served client, in circular order.
  function automatic int rr_pick(input logic [N-1:0] m);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (last + k) % N;
      if (m[c]) return c;
    end
    return 0;
  endfunction

  task automatic push_cfg(input logic [1:0] cfg);
    logic [15:0] d;
    d = div_of(cfg);
    bus_q.push_back('{1'b0, 2'b10, d[7:0]});
    bus_q.push_back('{1'b0, 2'b11, d[15:8]});
  endtask

  task automatic push_xfer(input int c, input logic rd, input logic [7:0] wd);
    logic [N-1:0] oh;
    oh = '0;
    oh[c] = 1'b1;
    if (rd) begin
      bus_q.push_back('{1'b1, 2'b00, rx_bytes[model_rd]});
      last_rd  = rx_bytes[model_rd];
      model_rd = model_rd + 8'd1;
    end else begin
      bus_q.push_back('{1'b0, 2'b00, wd});
    end
    done_q.push_back('{oh, last_rd});
    last = c;
  endtask

  task automatic set_req(input int c, input logic rd, input logic [7:0] wd);
    cli_if.req_rd[c]          = rd;
    cli_if.req_wdata[8*c +: 8] = wd;
    cli_if.req[c]             = 1'b1;
  endtask

  task automatic wait_done(input int budget);
    for (int k = 0; k < budget; k++) begin
      cli_if.req = cli_if.req & ~cli_if.done;
      if (cli_if.req == '0) break;
      tick();
    end
    check("req_served", 32'(cli_if.req), 32'd0);
    cli_if.req = '0;
  endtask

  task automatic wait_xfer(input int budget);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      tick();
      if (iocs && ioaddr == 2'b00) seen = 1'b1;
    end
    check("xfer_seen", 32'(seen), 32'd1);
  endtask

  task automatic drain();
    repeat (4) tick();
    check("queues_drained", 32'(bus_q.size() + done_q.size()), 32'd0);
  endtask

  initial begin : driver
    int nb;
    int n;
    bit seen;
    logic [N-1:0] mask, m;
    logic [N-1:0] rdv;
    logic [7:0]   wd [N];

    for (int i = 0; i < 256; i++) rx_bytes[i] = 8'($urandom);
    cli_if.req = '0;
    cli_if.req_rd = '0;
    cli_if.req_wdata = '0;

    // Reset, then the divisor sequence for br_cfg=10.
    repeat (3) tick();
    check("rst_iorw", 32'(iorw), 32'd1);
    check("rst_ioaddr", 32'(ioaddr), 32'd0);
    check("rst_rdata", 32'(cli_if.rdata), 32'd0);
    push_cfg(2'b10);
    @(posedge clk);
    #1 rst = 1'b1;
    nb = 0;
    repeat (6) begin
      @(negedge clk);
      nb += int'(cfg_busy);
    end
    #1;
    check("cfg_busy_cycles", 32'(nb), 32'd2);
    drain();

    // Client0 read of 8'h41.
    rda = 1'b1;
    rx_bytes[model_rd] = 8'h41;
    push_xfer(0, 1'b1, 8'h00);
    set_req(0, 1'b1, 8'h5A);
    wait_done(20);
    drain();

    // Two held writers alternate, one grant every 3 cycles.
    tbr = 1'b1;
    m = 3'b011;
    for (int g = 0; g < 4; g++) begin
      int c;
      c = rr_pick(m);
      push_xfer(c, 1'b0, (c == 0) ? 8'h55 : 8'hAA);
    end
    b2b_chk = 1'b1;
    set_req(0, 1'b0, 8'h55);
    set_req(1, 1'b0, 8'hAA);
    n = 0;
    for (int k = 0; k < 60 && n < 4; k++) begin
      tick();
      if (cli_if.done != '0) n++;
      if (n == 4) cli_if.req = '0;
    end
    check("alt_grants", 32'(n), 32'd4);
    b2b_chk = 1'b0;
    cli_if.req = '0;
    drain();

    // Client1 blocked by tbr=0 while client0 reads; client1 follows once tbr=1.
    tbr = 1'b0;
    push_xfer(0, 1'b1, 8'h00);
    push_xfer(1, 1'b0, 8'hBB);
    set_req(0, 1'b1, 8'h33);
    set_req(1, 1'b0, 8'hBB);
    repeat (10) begin
      tick();
      cli_if.req = cli_if.req & ~cli_if.done;
    end
    tbr = 1'b1;
    wait_done(20);
    drain();

    // cfg_load during XFER: transfer completes, divisor reprogrammed, then the next client.
    br_cfg = 2'b11;
    begin
      int ca, cb;
      ca = rr_pick(3'b011);
      cb = (ca == 0) ? 1 : 0;
      push_xfer(ca, 1'b0, (ca == 0) ? 8'h12 : 8'h34);
      push_cfg(2'b11);
      push_xfer(cb, 1'b0, (cb == 0) ? 8'h12 : 8'h34);
    end
    set_req(0, 1'b0, 8'h12);
    set_req(1, 1'b0, 8'h34);
    wait_xfer(10);
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    wait_done(30);
    drain();

    // A second cfg_load during the sequence is absorbed.
    br_cfg = 2'b01;
    push_cfg(2'b01);
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 5 && !seen; k++) begin
      tick();
      if (cfg_busy) seen = 1'b1;
    end
    check("cfg_started", 32'(seen), 32'd1);
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    repeat (8) tick();
    check("queues_drained", 32'(bus_q.size() + done_q.size()), 32'd0);

    // Reset during a write XFER: bus released, no done, divisor sequence restarts.
    bus_q.push_back('{1'b0, 2'b00, 8'hCC});
    set_req(0, 1'b0, 8'hCC);
    wait_xfer(10);
    rst = 1'b0;
    #1;
    check("rst_xfer_iocs", 32'(iocs), 32'd0);
    cli_if.req = '0;
    repeat (2) tick();
    check("rst_xfer_rdata", 32'(cli_if.rdata), 32'd0);
    last = N - 1;
    last_rd = 8'h00;
    br_cfg = 2'b00;
    push_cfg(2'b00);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (4) tick();
    drain();

    // Randomized rounds.
    rda = 1'b1;
    tbr = 1'b1;
    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 3) == 0) begin
        br_cfg = 2'($urandom);
        push_cfg(br_cfg);
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        repeat (5) tick();
      end
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        rdv[i] = 1'($urandom_range(0, 1));
        wd[i]  = 8'($urandom);
      end
      m = mask;
      while (m != '0) begin
        int c;
        c = rr_pick(m);
        push_xfer(c, rdv[c], wd[c]);
        m[c] = 1'b0;
      end
      for (int i = 0; i < N; i++)
        if (mask[i]) set_req(i, rdv[i], wd[i]);
      wait_done(80);
      repeat (2) tick();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
